seg7_scanner: RTL



---
 rtl/seg7_scanner.sv | 108 ++++++++++
 1 files changed

// File: rtl/seg7_scanner.sv
// Common-anode 4-digit seven-segment scanner with anti-ghosting guard and per-digit blink.
// Optional macro SEG7_DP_EN adds the DP input for per-digit decimal points.
module seg7_scanner #(
  parameter int SCAN_CNT    = 50000,
  parameter int BLINK_SCANS = 125
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [19:0] SEG7DATA,
  input  logic [3:0]  SEG7BLINK,
`ifdef SEG7_DP_EN
  input  logic [3:0]  DP,
`endif
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);

  localparam int PW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_CNT - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_SCANS - 1);

  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic [4:0]    w_code;
  logic [7:0]    w_seg;
  logic          w_slot_wrap;
  logic          w_scan_wrap;
  logic          w_dark;
  logic          w_dp_on;

  // Full 8-bit pattern including dp=1; the dp bit is overridden afterwards.
  function automatic logic [7:0] decode(input logic [4:0] code);
    logic [7:0] seg;
    seg = 8'hFF;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
        4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
        4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
        4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
      endcase
    end else if (code == 5'b10000) begin
      seg = 8'hBF;
    end
    return seg;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_code      = SEG7DATA[r_idx*5 +: 5];
    w_slot_wrap = (r_pcnt == PCNT_LAST);
    w_scan_wrap = w_slot_wrap && (r_idx == 2'd3);
    w_dark      = (r_pcnt == '0) || (r_phase && SEG7BLINK[r_idx]);
`ifdef SEG7_DP_EN
    w_dp_on     = DP[r_idx];
`else
    w_dp_on     = 1'b0;
`endif
    w_seg       = decode(w_code);
    w_seg[7]    = ~w_dp_on;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pcnt  <= '0;
      r_idx   <= 2'd0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_an    <= 4'b1111;
      r_seg   <= 8'hFF;
    end else begin
      if (w_slot_wrap) begin
        r_pcnt <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end

      if (w_scan_wrap) begin
        if (r_bcnt == BCNT_LAST) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end

      if (w_dark) begin
        r_an  <= 4'b1111;
        r_seg <= 8'hFF;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_seg;
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;

endmodule
